cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Control FSM sitting between the CPU and the direct-mapped word cache / data memory pair.
- Performs tag compare from the cache's Valid/Tag outputs and drives the cache's CacheRead, CacheWrite and fill strobes.
- Issues block-read and word-write requests to data memory over a request/ready handshake.
- Policy: write-through, word write-allocate; read miss fetches a 4-word block, then re-reads.

Parameters:
- ADDR_WIDTH, 10, CPU word address width.
- TAG_WIDTH, 3, tag bits = Address[ADDR_WIDTH-1 -: TAG_WIDTH].
- CNT_WIDTH, 16, width of the hit and miss statistics counters.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- MemRead  input  1  CPU read request; held stable while Stall=1.
- MemWrite  input  1  CPU write request; held stable while Stall=1.
- Address  input  ADDR_WIDTH  CPU word address; held stable while Stall=1.
- Valid  input  1  cache valid bit for Address.
- Tag  input  TAG_WIDTH  cache tag stored for Address.
- MemReady  input  1  data memory: current request completes this cycle.
- Stall  output  1  CPU must hold its request.
- CacheRead  output  1  cache read strobe.
- CacheWrite  output  1  cache word-write strobe.
- Fill  output  1  cache block-fill strobe; DataMemOut is valid this cycle.
- MemRdEn  output  1  data memory block-read request.
- MemWrEn  output  1  data memory word-write request.
- HitCount  output  CNT_WIDTH  read hits since reset, saturating.
- MissCount  output  CNT_WIDTH  read misses since reset, saturating.

Behaviour:
- Hit = Valid & (Tag == Address[ADDR_WIDTH-1 -: TAG_WIDTH]); combinational.
- States: IDLE, RD_MISS, RD_FILL, WR_WAIT. State is registered; strobes are decoded combinationally from state and inputs.
- Reset (RST=0, asynchronous):
  - state goes to IDLE; HitCount=0, MissCount=0.
  - All strobes and Stall evaluate to 0.
  - Any outstanding memory request is abandoned; memory must tolerate request withdrawal.
- IDLE:
  - MemRead & Hit: CacheRead=1, Stall=0, HitCount++, stay IDLE. Cache data is valid after the next edge.
  - MemRead & !Hit: Stall=1, MissCount++, next state RD_MISS. No cache strobe is asserted.
  - MemWrite (MemRead=0): CacheWrite=1 this cycle, Stall=1, next state WR_WAIT.
  - MemRead & MemWrite together: read takes priority, write is ignored. The CPU is not permitted to do this; the bench flags it as an error.
  - No request: all outputs 0.
  - MemReady is ignored in IDLE.
- RD_MISS:
  - MemRdEn=1, Stall=1.
  - MemReady=0: stay RD_MISS.
  - MemReady=1: Fill=1 the same cycle, next state RD_FILL.
- RD_FILL: CacheRead=1, Stall=1, MemRdEn=0, next state IDLE. The CPU sees Stall=0 in the following IDLE cycle, with data valid.
- WR_WAIT:
  - MemWrEn=1, Stall=1.
  - MemReady=1: next state IDLE.
  - The CacheWrite pulse is not repeated.
- Read-miss latency: 3 + N cycles from request to Stall low, where N = number of cycles MemReady stays 0 in RD_MISS.
- Write latency: 2 + N cycles.
- Counters:
  - Increment only on IDLE-cycle read decisions; writes are not counted.
  - A miss is counted once, not again on the refill read.
  - Both counters saturate at all-ones and do not wrap.
- Strobe exclusivity: at most one of CacheRead, CacheWrite, Fill is high in any cycle; MemRdEn and MemWrEn are never both high.
- No timeout: memory latency is unbounded.

Test Plan:
- Reset, then MemRead to Address 0x085 with Valid=0 → Stall=1 and MissCount=1; MemRdEn=1 next cycle. Assert MemReady after 4 cycles → Fill=1 in that cycle; CacheRead=1 next cycle; Stall=0 the cycle after.
- Cache model returns Valid=1, Tag=3'b001 for Address 0x085, then MemRead → CacheRead=1 same cycle, Stall=0, HitCount=1, no MemRdEn.
- Same index with tag mismatch (Address 0x305, stored Tag=1) → treated as a miss: MissCount increments, RD_MISS is entered.
- MemWrite to Address 0x010, MemReady held high → CacheWrite=1 for exactly 1 cycle, MemWrEn=1 for exactly 1 cycle, Stall low after 2 cycles. With MemReady delayed 3 cycles → Stall low after 5 cycles.
- RST=0 pulsed mid-RD_MISS → immediate IDLE, MemRdEn=0, counters 0; the next request is serviced normally.
- Force 2^CNT_WIDTH+5 read hits → HitCount holds at 0xFFFF.

Source files
------------

// File: rtl/cache_controller.sv
// Control FSM between the CPU and a direct-mapped word cache / data memory pair.
// Write-through, word write-allocate; a read miss fetches a 4-word block, then re-reads.
module cache_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  Valid,
  input  logic [TAG_WIDTH-1:0]  Tag,
  input  logic                  MemReady,
  output logic                  Stall,
  output logic                  CacheRead,
  output logic                  CacheWrite,
  output logic                  Fill,
  output logic                  MemRdEn,
  output logic                  MemWrEn,
  output logic [CNT_WIDTH-1:0]  HitCount,
  output logic [CNT_WIDTH-1:0]  MissCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    RD_FILL = 2'd2,
    WR_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t next_state_s;
  logic   hit_s;
  logic   hit_inc_s;
  logic   miss_inc_s;

  // Tag compare against the cache's stored tag for the indexed line
  always_comb begin
    hit_s = Valid & (Tag == Address[ADDR_WIDTH-1 -: TAG_WIDTH]);
  end

  // Next-state and strobe decode; everything is forced low while reset is held
  always_comb begin
    next_state_s = state_r;
    Stall        = 1'b0;
    CacheRead    = 1'b0;
    CacheWrite   = 1'b0;
    Fill         = 1'b0;
    MemRdEn      = 1'b0;
    MemWrEn      = 1'b0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    if (RST) begin
      case (state_r)
        IDLE: begin
          // Read wins if the CPU ever raises both requests
          if (MemRead) begin
            if (hit_s) begin
              CacheRead = 1'b1;
              hit_inc_s = 1'b1;
            end else begin
              Stall        = 1'b1;
              miss_inc_s   = 1'b1;
              next_state_s = RD_MISS;
            end
          end else if (MemWrite) begin
            CacheWrite   = 1'b1;
            Stall        = 1'b1;
            next_state_s = WR_WAIT;
          end else begin
            next_state_s = IDLE;
          end
        end
        RD_MISS: begin
          MemRdEn = 1'b1;
          Stall   = 1'b1;
          if (MemReady) begin
            Fill         = 1'b1;
            next_state_s = RD_FILL;
          end else begin
            next_state_s = RD_MISS;
          end
        end
        RD_FILL: begin
          CacheRead    = 1'b1;
          Stall        = 1'b1;
          next_state_s = IDLE;
        end
        WR_WAIT: begin
          MemWrEn = 1'b1;
          Stall   = 1'b1;
          if (MemReady) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = WR_WAIT;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end else begin
      next_state_s = IDLE;
    end
  end

  // State register and saturating hit/miss statistics
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      HitCount  <= {CNT_WIDTH{1'b0}};
      MissCount <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (hit_inc_s && (HitCount != CNT_MAX)) begin
        HitCount <= HitCount + CNT_ONE;
      end
      if (miss_inc_s && (MissCount != CNT_MAX)) begin
        MissCount <= MissCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a small direct-mapped tag model.
module tb_cache_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [9:0]  Address = 10'h000;
  logic        Valid;
  logic [2:0]  Tag;
  logic        MemReady = 1'b0;
  logic        Stall, CacheRead, CacheWrite, Fill, MemRdEn, MemWrEn;
  logic [15:0] HitCount, MissCount;

  int n_pass = 0;
  int n_total = 0;
  int stall_cnt;
  int cw_cnt;
  int wr_cnt;

  logic [127:0] mvalid = 128'd0;
  logic [2:0]   mtag [128];

  cache_controller #(.ADDR_WIDTH(10), .TAG_WIDTH(3), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Valid(Valid), .Tag(Tag), .MemReady(MemReady), .Stall(Stall), .CacheRead(CacheRead),
    .CacheWrite(CacheWrite), .Fill(Fill), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 CLK = ~CLK;

  // Cache tag store: index = Address[6:0], tag = Address[9:7], filled on Fill
  assign Valid = mvalid[Address[6:0]];
  assign Tag   = mtag[Address[6:0]];
  always @(posedge CLK) begin
    if (Fill) begin
      mvalid[Address[6:0]] <= 1'b1;
      mtag[Address[6:0]]   <= Address[9:7];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobe exclusivity, sampled mid-cycle throughout the run
  always @(negedge CLK) begin
    chk("excl_cache", 32'(CacheRead) + 32'(CacheWrite) + 32'(Fill) <= 32'd1, 1'b1);
    chk("excl_mem", MemRdEn & MemWrEn, 1'b0);
  end

  initial begin
    // Reset with a pending read: everything must stay low
    MemRead = 1'b1; Address = 10'h085;
    tick(); tick(); #1;
    chk("rst_stall", Stall, 1'b0);
    chk("rst_cread", CacheRead, 1'b0);
    chk("rst_hit", HitCount, 16'd0);
    chk("rst_miss", MissCount, 16'd0);
    MemRead = 1'b0;
    tick(); RST = 1'b1;

    // Read miss to 0x085, memory ready after 4 wait cycles
    tick(); MemRead = 1'b1; Address = 10'h085; #1;
    chk("miss_stall", Stall, 1'b1);
    chk("miss_nocread", CacheRead, 1'b0);
    chk("miss_nordmem", MemRdEn, 1'b0);
    tick(); #1;
    chk("miss_cnt", MissCount, 16'd1);
    chk("rdmiss_rden", MemRdEn, 1'b1);
    chk("rdmiss_nofill", Fill, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rdmiss_wait", MemRdEn & Stall & ~Fill, 1'b1);
    end
    tick(); MemReady = 1'b1; #1;
    chk("fill", Fill, 1'b1);
    chk("fill_rden", MemRdEn, 1'b1);
    tick(); MemReady = 1'b0; #1;
    chk("rdfill_cread", CacheRead, 1'b1);
    chk("rdfill_stall", Stall, 1'b1);
    chk("rdfill_rden", MemRdEn, 1'b0);
    // Re-read now hits the freshly filled line
    tick(); #1;
    chk("reread_stall", Stall, 1'b0);
    chk("reread_cread", CacheRead, 1'b1);
    chk("reread_rden", MemRdEn, 1'b0);
    tick(); MemRead = 1'b0; #1;
    chk("hit_cnt1", HitCount, 16'd1);
    chk("miss_once", MissCount, 16'd1);

    // Same index, different tag: 0x305 misses against stored tag 1
    tick(); MemRead = 1'b1; Address = 10'h305; #1;
    chk("tagmm_valid", Valid, 1'b1);
    chk("tagmm_stall", Stall, 1'b1);
    chk("tagmm_cread", CacheRead, 1'b0);
    tick(); MemReady = 1'b1; #1;
    chk("tagmm_miss", MissCount, 16'd2);
    chk("tagmm_fill", Fill, 1'b1);
    tick(); MemReady = 1'b0; #1;
    chk("tagmm_rdfill", CacheRead, 1'b1);
    tick(); #1;
    chk("tagmm_done", Stall, 1'b0);
    tick(); MemRead = 1'b0; #1;
    chk("tagmm_hit", HitCount, 16'd2);

    // Write with memory ready immediately: 2 stall cycles
    tick(); MemWrite = 1'b1; Address = 10'h010; MemReady = 1'b1; #1;
    chk("wr_cwrite", CacheWrite, 1'b1);
    chk("wr_stall", Stall, 1'b1);
    chk("wr_nowren", MemWrEn, 1'b0);
    tick(); #1;
    chk("wrwait_wren", MemWrEn, 1'b1);
    chk("wrwait_cwrite", CacheWrite, 1'b0);
    chk("wrwait_stall", Stall, 1'b1);
    tick(); MemWrite = 1'b0; MemReady = 1'b0; #1;
    chk("wr_done", Stall | MemWrEn | CacheWrite, 1'b0);
    chk("wr_nocount", HitCount + MissCount, 16'd4);

    // Write with memory delayed 3 cycles: 5 stall cycles
    stall_cnt = 0; cw_cnt = 0; wr_cnt = 0;
    tick(); MemWrite = 1'b1; Address = 10'h010;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) MemReady = 1'b1;
      #1;
      stall_cnt += 32'(Stall); cw_cnt += 32'(CacheWrite); wr_cnt += 32'(MemWrEn);
      tick();
    end
    MemWrite = 1'b0; MemReady = 1'b0; #1;
    chk("wrdly_stalls", stall_cnt, 32'd5);
    chk("wrdly_cwrite", cw_cnt, 32'd1);
    chk("wrdly_wren", wr_cnt, 32'd4);
    chk("wrdly_done", Stall, 1'b0);

    // Reset in the middle of RD_MISS
    tick(); MemRead = 1'b1; Address = 10'h200; #1;
    chk("rstmid_miss", Stall, 1'b1);
    tick(); #1;
    chk("rstmid_rden", MemRdEn, 1'b1);
    RST = 1'b0; #1;
    chk("rstmid_rden0", MemRdEn, 1'b0);
    chk("rstmid_stall0", Stall, 1'b0);
    chk("rstmid_hit0", HitCount, 16'd0);
    chk("rstmid_miss0", MissCount, 16'd0);
    tick(); RST = 1'b1; #1;
    chk("rstmid_again", Stall, 1'b1);
    tick(); MemReady = 1'b1; #1;
    chk("rstmid_rden1", MemRdEn, 1'b1);
    chk("rstmid_misscnt", MissCount, 16'd1);
    tick(); MemReady = 1'b0; #1;
    chk("rstmid_rdfill", CacheRead, 1'b1);
    tick(); #1;
    chk("rstmid_done", Stall, 1'b0);

    // Saturation: far more than 2^16 hits on the filled line at 0x200
    repeat (65541) @(posedge CLK);
    #1;
    chk("sat_hit", HitCount, 16'hFFFF);
    chk("sat_miss", MissCount, 16'd1);
    chk("sat_stall", Stall, 1'b0);
    tick(); MemRead = 1'b0; #1;
    chk("sat_hold", HitCount, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
